// File: rtl/pong_input_pkg.sv
// Shared constants for the Pong PS/2 input path: set-2 scan codes, key ids,
// ASCII values, decoder state encoding and the event byte layout.
package pong_input_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_O     = 8'h44;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [2:0] KEY_W     = 3'd0;
  localparam logic [2:0] KEY_S     = 3'd1;
  localparam logic [2:0] KEY_O     = 3'd2;
  localparam logic [2:0] KEY_K     = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;

  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_O     = 8'h4F;
  localparam logic [7:0] ASCII_K     = 8'h4B;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam int EVT_REL_BIT = 7;
  localparam int EVT_ID_MSB  = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Returns {tracked, key_id}; untracked codes give 4'b0000.
  function automatic logic [3:0] lookup_key(input logic [7:0] code);
    case (code)
      SC_W:     return {1'b1, KEY_W};
      SC_S:     return {1'b1, KEY_S};
      SC_O:     return {1'b1, KEY_O};
      SC_K:     return {1'b1, KEY_K};
      SC_SPACE: return {1'b1, KEY_SPACE};
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] key_ascii(input logic [2:0] id);
    case (id)
      KEY_W:     return ASCII_W;
      KEY_S:     return ASCII_S;
      KEY_O:     return ASCII_O;
      KEY_K:     return ASCII_K;
      KEY_SPACE: return ASCII_SPACE;
      default:   return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word fall-through event FIFO with occupancy count and a sticky
// overflow flag raised whenever a push is dropped for lack of space.
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clr_overflow,
  output logic [WIDTH-1:0]             head_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  assign valid     = ~empty;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only visible through head_data while non-empty.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the sticky overflow flag (a new drop wins over a clear).
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break sequences for the Pong keys (W, S, O, K, Space)
// into a held-key bitmap and a press/release event FIFO.
// Optional build macro: TYPEMATIC_FILTER_EN suppresses events for repeated makes
// of a held key and for breaks of a key that is not held.
module ps2_key_tracker
  import pong_input_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 500000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ps2_key_pressed,
  input  logic [7:0]                       ps2_key_data,
  input  logic                             pop,
  input  logic                             clr_overflow,
  output logic [4:0]                       key_held,
  output logic                             evt_valid,
  output logic [7:0]                       evt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  evt_count,
  output logic                             overflow,
  output logic [7:0]                       last_ascii
);

  localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  dec_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic          prev_pressed;
  logic          byte_accept;
  logic [3:0]    key_info;
  logic          tracked;
  logic [2:0]    key_id;
  logic          evt_push;
  logic [7:0]    evt_word;

  assign byte_accept = ps2_key_pressed & ~prev_pressed;
  assign key_info    = lookup_key(ps2_key_data);
  assign tracked     = key_info[3];
  assign key_id      = key_info[2:0];

  // Previous level of the byte-valid strobe; resets high so a level already up is not a new byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_pressed <= 1'b1;
    end else begin
      prev_pressed <= ps2_key_pressed;
    end
  end

  // Builds the event word for a tracked make or break and decides whether it is queued.
  always_comb begin
    evt_push = 1'b0;
    evt_word = '0;
    evt_word[EVT_ID_MSB:0] = key_id;
    if (byte_accept && tracked) begin
      case (state)
        ST_IDLE: begin
`ifdef TYPEMATIC_FILTER_EN
          evt_push = ~key_held[key_id];
`else
          evt_push = 1'b1;
`endif
        end
        ST_BRK: begin
`ifdef TYPEMATIC_FILTER_EN
          evt_push = key_held[key_id];
`else
          evt_push = 1'b1;
`endif
          evt_word[EVT_REL_BIT] = 1'b1;
        end
        default: evt_push = 1'b0;
      endcase
    end
  end

  // Decoder FSM with prefix timeout; also owns the held bitmap and last ASCII code.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      key_held   <= '0;
      last_ascii <= '0;
    end else if (byte_accept) begin
      tmo_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == SC_BREAK) begin
            state <= ST_BRK;
          end else if (ps2_key_data == SC_EXT) begin
            state <= ST_EXT;
          end else if (tracked) begin
            key_held[key_id] <= 1'b1;
            last_ascii       <= key_ascii(key_id);
          end
        end
        ST_BRK: begin
          if (tracked) begin
            key_held[key_id] <= 1'b0;
          end
          state <= ST_IDLE;
        end
        ST_EXT: begin
          state <= (ps2_key_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        state   <= ST_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (evt_push),
    .push_data    (evt_word),
    .pop          (pop),
    .clr_overflow (clr_overflow),
    .head_data    (evt_data),
    .valid        (evt_valid),
    .count        (evt_count),
    .overflow     (overflow)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: a key-level reference model queues the
// expected events and a monitor drains and compares the DUT's FIFO head.
module tb_ps2_key_tracker;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       pop = 1'b0;
  logic       clr_overflow;
  logic [4:0] key_held;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic [2:0] evt_count;
  logic       overflow;
  logic [7:0] last_ascii;

  int checks   = 0;
  int failures = 0;

  logic       drain_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] prefix_q[$];
  logic [4:0] m_held  = '0;
  logic [7:0] m_ascii = '0;
  bit         exp_ovf = 1'b0;
  bit         last_drop;

  logic [7:0] codes [5] = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'h29};
  logic [7:0] asc   [5] = '{8'h57, 8'h53, 8'h4F, 8'h4B, 8'h20};

  ps2_key_tracker #(
    .FIFO_DEPTH     (DEPTH),
    .PREFIX_TIMEOUT (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_key_data    (ps2_key_data),
    .pop             (pop),
    .clr_overflow    (clr_overflow),
    .key_held        (key_held),
    .evt_valid       (evt_valid),
    .evt_data        (evt_data),
    .evt_count       (evt_count),
    .overflow        (overflow),
    .last_ascii      (last_ascii)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int key_index(input logic [7:0] b);
    for (int i = 0; i < 5; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  // Reference model: interprets one accepted byte at the key/prefix level.
  task automatic model_byte(input logic [7:0] b);
    int k;
    bit want;
    logic [7:0] ev;
    k = key_index(b);
    want = 0;
    ev = 8'h00;
    last_drop = 0;
    if (prefix_q.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) begin
        prefix_q.push_back(b);
      end else if (k >= 0) begin
`ifdef TYPEMATIC_FILTER_EN
        want = !m_held[k];
`else
        want = 1;
`endif
        m_held[k] = 1'b1;
        m_ascii = asc[k];
        ev = 8'(k);
      end
    end else if (prefix_q.size() == 1 && prefix_q[0] == 8'hF0) begin
      if (k >= 0) begin
`ifdef TYPEMATIC_FILTER_EN
        want = m_held[k];
`else
        want = 1;
`endif
        m_held[k] = 1'b0;
        ev = 8'h80 | 8'(k);
      end
      prefix_q.delete();
    end else if (prefix_q.size() == 1 && prefix_q[0] == 8'hE0 && b == 8'hF0) begin
      prefix_q.push_back(b);
    end else begin
      prefix_q.delete();
    end
    if (want) begin
      if (!drain_en && exp_q.size() >= DEPTH) begin
        exp_ovf = 1;
        last_drop = 1;
      end else begin
        exp_q.push_back(ev);
      end
    end
  endtask

  // Monitor: pops and compares the FIFO head every cycle draining is enabled.
  always @(negedge clock) begin
    logic [7:0] e;
    pop = 1'b0;
    if (drain_en && evt_valid && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {24'd0, evt_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("evt_data", {24'd0, evt_data}, {24'd0, e});
      end
      pop = 1'b1;
    end
  end

  task automatic check_output();
    check("key_held", {27'd0, key_held}, {27'd0, m_held});
    check("last_ascii", {24'd0, last_ascii}, {24'd0, m_ascii});
    check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    if (!drain_en) check("evt_count", {29'd0, evt_count}, exp_q.size());
  endtask

  // Sends one byte as a high pulse of 'hold' cycles, optionally with a same-cycle pop or overflow clear.
  task automatic apply_stimulus(input logic [7:0] b, input int hold = 2, input int gap = 2,
                                input bit pulse_pop = 0, input bit pulse_clr = 0);
    @(posedge clock); #1;
    ps2_key_pressed = 1'b1;
    ps2_key_data = b;
    if (pulse_pop) drain_en = 1'b1;
    if (pulse_clr) clr_overflow = 1'b1;
    @(negedge clock); #1;
    drain_en = pulse_pop ? 1'b0 : drain_en;
    model_byte(b);
    if (pulse_clr && !last_drop) exp_ovf = 0;
    @(posedge clock); #1;
    clr_overflow = 1'b0;
    repeat (hold - 1) @(posedge clock);
    #1 ps2_key_pressed = 1'b0;
    check_output();
    repeat (gap) @(posedge clock);
  endtask

  task automatic wait_drain();
    drain_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (exp_q.size() == 0 && !evt_valid) break;
    end
    check("drain_empty", {31'd0, (exp_q.size() == 0 && !evt_valid)}, 32'd1);
  endtask

  task automatic check_cleared();
    check("rst_key_held", {27'd0, key_held}, 32'd0);
    check("rst_evt_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_evt_data", {24'd0, evt_data}, 32'd0);
    check("rst_evt_count", {29'd0, evt_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_last_ascii", {24'd0, last_ascii}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] pool [9];
    logic [7:0] b;
    pool = '{8'h1D, 8'h1B, 8'h44, 8'h42, 8'h29, 8'hF0, 8'hF0, 8'hE0, 8'h00};
    reset = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data = 8'h00;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_cleared();

    // 1: W make then break
    drain_en = 1'b1;
    apply_stimulus(8'h1D, 3);
    check("t1_ascii_w", {24'd0, last_ascii}, 32'h57);
    apply_stimulus(8'hF0, 3);
    apply_stimulus(8'h1D, 3);
    wait_drain();

    // 2: long level is a single byte
    drain_en = 1'b0;
    apply_stimulus(8'h44, 20);
    check("t2_count", {29'd0, evt_count}, 32'd1);
    wait_drain();

    // 3: extended sequences ignored; prefix timeout
    apply_stimulus(8'hE0); apply_stimulus(8'h1D);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h1D);
    apply_stimulus(8'hF0);
    repeat (TMO + 5) @(posedge clock);
    prefix_q.delete();
    apply_stimulus(8'h42);
    check("t3_k_held", {31'd0, key_held[3]}, 32'd1);
    wait_drain();

    // 4: overflow, clear/drop race, push+pop when full
    apply_stimulus(8'hF0); apply_stimulus(8'h44);
    apply_stimulus(8'hF0); apply_stimulus(8'h42);
    wait_drain();
    drain_en = 1'b0;
    foreach (codes[i]) apply_stimulus(codes[i]);
    check("t4_count_full", {29'd0, evt_count}, 32'd4);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    check("t4_head", {24'd0, evt_data}, {24'd0, exp_q[0]});
    apply_stimulus(8'hF0);
    apply_stimulus(8'h44, 2, 2, 0, 1);
    @(posedge clock); #1 clr_overflow = 1'b1;
    @(posedge clock); #1 clr_overflow = 1'b0;
    exp_ovf = 0;
    check_output();
    apply_stimulus(8'hF0);
    apply_stimulus(8'h1D, 2, 2, 1, 0);
    check("t4_count_pushpop", {29'd0, evt_count}, 32'd4);
    check("t4_no_drop", {31'd0, overflow}, 32'd0);
    wait_drain();

    // 5: typematic repeats of Space
    apply_stimulus(8'hF0); apply_stimulus(8'h29);
    wait_drain();
    drain_en = 1'b0;
    repeat (3) apply_stimulus(8'h29);
`ifdef TYPEMATIC_FILTER_EN
    check("t5_count", {29'd0, evt_count}, 32'd1);
`else
    check("t5_count", {29'd0, evt_count}, 32'd3);
`endif
    check("t5_space_held", {31'd0, key_held[4]}, 32'd1);
    wait_drain();

    // 6: reset mid-prefix with events queued and strobe high
    drain_en = 1'b0;
    apply_stimulus(8'hF0); apply_stimulus(8'h29);
    apply_stimulus(8'hF0); apply_stimulus(8'h1B);
    check("t6_queued", {29'd0, evt_count}, 32'd2);
    @(posedge clock); #1;
    ps2_key_pressed = 1'b1;
    ps2_key_data = 8'hF0;
    @(negedge clock); #1 model_byte(8'hF0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_held = '0; m_ascii = '0; exp_q.delete(); prefix_q.delete(); exp_ovf = 0;
    check_cleared();
    repeat (3) @(posedge clock);
    #1 check_cleared();
    ps2_key_pressed = 1'b0;
    drain_en = 1'b1;
    apply_stimulus(8'h1D);
    wait_drain();

    // Random byte stream with continuous draining
    for (int n = 0; n < 120; n++) begin
      b = pool[$urandom_range(0, 8)];
      if (b == 8'h00) b = 8'($urandom_range(0, 255));
      apply_stimulus(b, $urandom_range(1, 4), $urandom_range(0, 4));
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
